// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, instruction register with valid/ready to decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_write,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DROP,
    S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] req_pc;
  logic              can_issue;
  logic              issue;
  logic              capture;
  logic              kill;
  logic              release_instr;
  logic              fault_set;
  logic              fault_clr;

  always_comb begin
    state_n       = state;
    issue         = 1'b0;
    capture       = 1'b0;
    kill          = 1'b0;
    release_instr = 1'b0;
    fault_set     = 1'b0;
    fault_clr     = 1'b0;
    can_issue     = fetch_en && !flush &&
                    ((state == S_IDLE) || ((state == S_HOLD) && instr_ready));

    // Issue decision is shared by IDLE and HOLD; the case below refines HOLD exits.
    if (can_issue) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pc[1:0] != 2'b00) begin
        fault_set = 1'b1;
        state_n   = S_FAULT;
      end else
`endif
      begin
        issue   = 1'b1;
        state_n = S_WAIT;
      end
    end

    case (state)
      S_WAIT: begin
        if (imem_rvalid) begin
          capture = !flush;
          state_n = flush ? S_IDLE : S_HOLD;
        end else if (flush) begin
          state_n = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_n = S_IDLE;
      end
      S_HOLD: begin
        if (flush) begin
          kill    = 1'b1;
          state_n = S_IDLE;
        end else if (instr_ready) begin
          release_instr = 1'b1;
          if (!can_issue) state_n = S_IDLE;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        if (flush) begin
          fault_clr = 1'b1;
          state_n   = S_IDLE;
        end
      end
`endif
      default: ;
    endcase

    imem_req  = issue && !reset;
    pc_write  = issue && !reset;
    imem_addr = (issue && !reset) ? pc : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      req_pc      <= '0;
    end else begin
      state <= state_n;
      if (issue) req_pc <= pc;
      if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= req_pc;
        instr_valid <= 1'b1;
      end else if (kill) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end else if (release_instr) begin
        instr_valid <= 1'b0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (fault_set) instr_pc <= pc;
`endif
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (fault_set) begin
      fetch_fault <= 1'b1;
    end else if (fault_clr) begin
      fetch_fault <= 1'b0;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions queued when the memory response is driven,
// popped and compared when decode observes instr_valid.
module tb_fetch_unit;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h00000013;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic              pc_write;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              fetch_fault;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc), .pc_write(pc_write),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1ns after the rising edge; outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    sb.push_back(e);
  endtask

  task automatic check_instr(input string tag);
    exp_t e;
    check({tag, "_valid"}, 64'(instr_valid), 64'd1);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, 64'(instr), 64'(e.data));
      check({tag, "_pc"}, 64'(instr_pc), 64'(e.pc));
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_instr"}, 64'(instr), 64'(NOP));
    check({tag, "_ipc"}, 64'(instr_pc), 64'd0);
    check({tag, "_fault"}, 64'(fetch_fault), 64'd0);
    check({tag, "_req"}, 64'(imem_req), 64'd0);
    check({tag, "_pcw"}, 64'(pc_write), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b1; pc = 32'h0; flush = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    step();
    step();
    check_idle_outs("rst");

    // basic fetch, L=1
    reset = 1'b0;
    settle();
    check("issue0_req", 64'(imem_req), 64'd1);
    check("issue0_pcw", 64'(pc_write), 64'd1);
    check("issue0_addr", 64'(imem_addr), 64'd0);
    step();
    pc = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
    push_exp(32'h00500093, 32'h0);
    settle();
    check("wait_noreq", 64'(imem_req), 64'd0);
    check("wait_nopcw", 64'(pc_write), 64'd0);
    step();
    imem_rvalid = 1'b0; imem_rdata = '0;
    settle();
    check_instr("f0");

    // decode stalls for 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 64'(imem_req), 64'd0);
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_instr", 64'(instr), 64'h00500093);
      check("stall_pc", 64'(instr_pc), 64'h0);
      step();
    end

    // back-to-back issue on acceptance
    instr_ready = 1'b1; pc = 32'h4;
    settle();
    check("b2b_req", 64'(imem_req), 64'd1);
    check("b2b_pcw", 64'(pc_write), 64'd1);
    check("b2b_addr", 64'(imem_addr), 64'h4);
    step();
    instr_ready = 1'b0; pc = 32'h8;
    imem_rvalid = 1'b1; imem_rdata = 32'h00a00113;
    push_exp(32'h00a00113, 32'h4);
    settle();
    check("b2b_wait_valid", 64'(instr_valid), 64'd0);
    step();
    imem_rvalid = 1'b0;
    settle();
    check_instr("f1");

    // flush in HOLD beats instr_ready
    instr_ready = 1'b1; flush = 1'b1;
    settle();
    check("hflush_req", 64'(imem_req), 64'd0);
    check("hflush_pcw", 64'(pc_write), 64'd0);
    step();
    flush = 1'b0; instr_ready = 1'b0; fetch_en = 1'b0;
    settle();
    check("hflush_valid", 64'(instr_valid), 64'd0);
    check("hflush_instr", 64'(instr), 64'(NOP));

    // flush one cycle after issue, memory L=3 -> DROP
    fetch_en = 1'b1;
    settle();
    check("drop_issue_req", 64'(imem_req), 64'd1);
    check("drop_issue_addr", 64'(imem_addr), 64'h8);
    step();
    fetch_en = 1'b0; flush = 1'b1; pc = 32'hC;
    step();
    flush = 1'b0; fetch_en = 1'b1;
    settle();
    check("drop_noreq", 64'(imem_req), 64'd0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    settle();
    check("drop_noreq2", 64'(imem_req), 64'd0);
    step();
    imem_rvalid = 1'b0; imem_rdata = '0;
    settle();
    check("drop_valid", 64'(instr_valid), 64'd0);
    check("drop_instr", 64'(instr), 64'(NOP));
    check("drop_reissue_req", 64'(imem_req), 64'd1);
    check("drop_reissue_addr", 64'(imem_addr), 64'hC);

    // fetch_en dropped mid-WAIT: response still captured
    step();
    fetch_en = 1'b0; pc = 32'h10;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h00c00193;
    push_exp(32'h00c00193, 32'hC);
    step();
    imem_rvalid = 1'b0;
    settle();
    check_instr("f2");
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    settle();
    check("accept_valid", 64'(instr_valid), 64'd0);
    check("accept_idle_req", 64'(imem_req), 64'd0);

    // reset mid-WAIT, then late response in IDLE
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0; reset = 1'b1;
    settle();
    check_idle_outs("rstwait");
    step();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
    step();
    imem_rvalid = 1'b0;
    settle();
    check_idle_outs("late");

    // misaligned PC at issue
    fetch_en = 1'b1; pc = 32'h6;
    settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_req", 64'(imem_req), 64'd0);
    check("mis_pcw", 64'(pc_write), 64'd0);
    step();
    pc = 32'h8;
    settle();
    check("mis_fault", 64'(fetch_fault), 64'd1);
    check("mis_ipc", 64'(instr_pc), 64'h6);
    check("mis_valid", 64'(instr_valid), 64'd0);
    check("mis_sticky_req", 64'(imem_req), 64'd0);
    step();
    check("mis_sticky", 64'(fetch_fault), 64'd1);
    flush = 1'b1; fetch_en = 1'b0;
    step();
    flush = 1'b0; fetch_en = 1'b1;
    settle();
    check("mis_clr", 64'(fetch_fault), 64'd0);
    check("mis_idle_req", 64'(imem_req), 64'd1);
    check("mis_idle_addr", 64'(imem_addr), 64'h8);
`else
    check("mis_req", 64'(imem_req), 64'd1);
    check("mis_addr", 64'(imem_addr), 64'h6);
    step();
    fetch_en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00f00213;
    push_exp(32'h00f00213, 32'h6);
    step();
    imem_rvalid = 1'b0;
    settle();
    check_instr("mis");
    check("mis_fault", 64'(fetch_fault), 64'd0);
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Reads the current PC, issues one instruction-memory read per fetch and pulses pc_write so the PC advances.
- Captures the returned word into an instruction register and hands it to decode over a valid/ready handshake.
- Supports flush/redirect with discard of an in-flight response. One outstanding request max.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- NOP_INSTR, 32'h00000013, value held in instr while no valid instruction (reset/flush).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- fetch_en  in  1  permits issuing new fetches.
- pc  in  ADDR_W  current PC from the PC register.
- pc_write  out  1  combinational; one-cycle pulse telling the PC register to load next_pc at this edge.
- flush  in  1  redirect/kill; squashes held and in-flight instruction.
- imem_req  out  1  combinational; one-cycle read request.
- imem_addr  out  ADDR_W  combinational; equals pc when imem_req=1, else 0.
- imem_rvalid  in  1  read data valid; ≥1 cycle after imem_req.
- imem_rdata  in  DATA_W  read data.
- instr_valid  out  1  registered; instruction available to decode.
- instr  out  DATA_W  registered instruction register.
- instr_pc  out  ADDR_W  registered PC of instr.
- instr_ready  in  1  decode accepts instr this cycle.
- fetch_fault  out  1  misaligned-PC fault (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset is asynchronous, active-high.
  - State=IDLE, instr_valid=0, instr=NOP_INSTR, instr_pc=0, fetch_fault=0, internal req_pc=0.
  - Combinational outputs are 0 while reset=1.
- Issue condition (IDLE, or HOLD with instr_ready=1): fetch_en=1 and flush=0.
  - Same cycle: imem_req=1, imem_addr=pc, pc_write=1, req_pc<=pc. Next state WAIT.
  - Exactly one imem_req and one pc_write per fetch.
- IDLE:
  - Issue → WAIT; otherwise stay.
  - imem_rvalid in IDLE is ignored.
- WAIT:
  - imem_rvalid=1 and flush=0: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1 → HOLD.
  - imem_rvalid=1 and flush=1: discard → IDLE.
  - imem_rvalid=0 and flush=1: → DROP.
  - No request is issued in WAIT.
- DROP: waits for the stale response.
  - imem_rvalid=1 discards the data → IDLE.
  - flush has no further effect.
  - No issue in DROP.
- HOLD: instr_valid=1; instr and instr_pc stable until accepted.
  - flush=1 (priority over instr_ready): instr_valid<=0, instr<=NOP_INSTR → IDLE. No issue.
  - instr_ready=1 and issue condition: back-to-back issue → WAIT; instr_valid<=0 at the edge.
  - instr_ready=1 and fetch_en=0: instr_valid<=0 → IDLE.
  - instr_ready=0: hold.
- Latency:
  - Issue edge to instr_valid = memory latency L cycles; instr_valid rises on the edge where rvalid is sampled.
  - Throughput with L=1 and decode always ready: one instruction per 2 cycles.
- fetch_en deasserted mid-WAIT does not cancel the request; the response is still captured.
- Reset asserted mid-WAIT or mid-DROP: the response is lost, state returns to IDLE. A late imem_rvalid arriving in IDLE is ignored.
- pc is sampled only at issue. Changes to pc at other times have no effect.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: at an issue point with pc[1:0]!=0:
  - No imem_req, no pc_write; enter FAULT state.
  - fetch_fault=1 (registered, sticky); instr_pc<=pc; instr_valid stays 0.
  - FAULT exits to IDLE only on flush or reset, which clear fetch_fault.
- Undefined: address alignment is not checked; fetch_fault is tied to 0; no FAULT state exists.

Test Plan:
- Reset, pc=0x00000000, fetch_en=1, memory L=1 returning 0x00500093 → imem_req/pc_write pulse with imem_addr=0 in cycle 1; instr_valid=1, instr=0x00500093, instr_pc=0 after the next edge.
- Decode holds instr_ready=0 for 3 cycles in HOLD → instr, instr_pc and instr_valid stable, no imem_req. Then instr_ready=1 with pc=0x4 → back-to-back imem_req with imem_addr=0x4 in that same cycle.
- flush asserted 1 cycle after issue, memory L=3 → DROP; rdata 0xDEADBEEF discarded, instr_valid stays 0; next fetch issues after returning to IDLE.
- flush while in HOLD with instr_ready=1 → instr_valid=0, instr=NOP_INSTR (0x00000013) next cycle; no imem_req that cycle.
- Reset asserted mid-WAIT, then a late imem_rvalid with 0x12345678 → all outputs at reset values, response ignored, instr_valid=0.
- With FETCH_MISALIGN_TRAP_EN, pc=0x00000006 at issue → no imem_req, no pc_write, fetch_fault=1, instr_pc=0x6. After flush → fetch_fault=0, state IDLE. Without the macro, the same stimulus → imem_addr=0x6, fetch_fault=0.
